regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Writeback scheduler and hazard scoreboard for the 2R/1W register file.
//  Two writeback sources (ALU, load unit) share the single write port through a round-robin arbiter.
//  Per-register busy bits track issued-but-unwritten destinations and stall issue on RAW/WAW hazards.
//  Sits between the issue stage, the execute/memory writeback paths and the register file write port.
// PARAMETERS
//  NREG  32  number of architectural registers
//  AW    5   register index width (clog2(NREG))
//  DW    32  data width
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  issue_valid   in   1   instruction presented for issue
//  issue_wr      in   1   instruction writes rd
//  issue_rd      in   AW  destination index
//  issue_rs1     in   AW  source 1 index
//  issue_rs2     in   AW  source 2 index
//  issue_stall   out  1   hazard; issue not accepted this cycle
//  alu_wb_valid  in   1   ALU writeback request
//  alu_wb_num    in   AW  ALU writeback index
//  alu_wb_data   in   DW  ALU writeback data
//  alu_wb_ready  out  1   ALU request granted this cycle
//  mem_wb_valid / mem_wb_num / mem_wb_data / mem_wb_ready: same as alu_wb_* for the load unit
//  RegWrite      out  1   register file write enable (registered)
//  WbRegNum      out  AW  register file write index (registered)
//  WbData        out  DW  register file write data (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): busy[*]=0, RegWrite=0, WbRegNum=0, WbData=0, rr_last=MEM (ALU wins first tie).
//  issue_stall is combinational from the current busy[] state; it is not a registered output:
//   issue_valid & ((busy[rs1]&rs1!=0) | (busy[rs2]&rs2!=0) | (issue_wr&busy[rd]&rd!=0)).
//  Issue is accepted when issue_valid & !issue_stall; if issue_wr & rd!=0, set busy[rd] at that edge.
//  Arbitration is combinational and uses the current rr_last:
//   one source valid -> grant it;
//   both valid -> grant the source != rr_last;
//   rr_last updates to the granted source at that edge.
//  Handshake: a request completes on the cycle valid & ready; requesters hold num/data stable until ready.
//  Latency: a granted request appears on RegWrite/WbRegNum/WbData exactly 1 cycle later, for exactly 1 cycle.
//  No grant -> RegWrite=0 next cycle; WbRegNum/WbData hold their last values.
//  r0: wb_num==0 is granted and consumed normally, but RegWrite stays 0; busy[0] is never set.
//  busy[n] clears on the edge where the granted write to n is registered, i.e. before RegWrite=1 for n.
//   Issue sees n free in the same cycle RegWrite=1 for n.
//   The regfile read returns the new value only in the following cycle, so the issue stage
//   compares against WbRegNum itself.
//  Same edge sets and clears busy[n] (new issue to n while the old write retires): set wins.
//   This cannot occur for the same n under WAW stall; keep set-wins as a defensive rule.
//  Writeback to a non-busy register is legal (no assertion); it writes normally.
//  Reset mid-operation: all pending busy bits and in-flight writes are dropped; requesters must re-present.
// STRUCTURE
//  Shared package regfile_pkg: NREG/AW/DW constants, typedef enum {SRC_ALU, SRC_MEM} wb_src_t.
//  Sub-module rr_arb2: 2-input round-robin arbiter (req[1:0] -> gnt[1:0], last-grant state).
//  Top-level logic: busy[NREG-1:0] scoreboard, hazard compare, output write register.
// TESTING
//  Reset then only ALU valid (num=5, data=0xA5):
//   alu_wb_ready=1 same cycle; next cycle RegWrite=1, WbRegNum=5, WbData=0xA5.
//  ALU and MEM both valid for 4 cycles after reset:
//   grants alternate ALU, MEM, ALU, MEM; RegWrite=1 on 4 consecutive cycles.
//  Issue rd=7 (wr=1), then issue rs1=7:
//   issue_stall=1 until ALU writeback to 7 is registered; stall drops in the same cycle RegWrite=1, WbRegNum=7.
//  Issue rd=3 then a second issue with rd=3:
//   second issue stalls (WAW) until the first writeback to 3 retires.
//  MEM writeback num=0, data=0xFFFF:
//   mem_wb_ready=1, RegWrite stays 0; issue rd=0 never sets busy, and rs1=0 never stalls.
//  Assert rst_n=0 with busy[4]=1 and a grant pending:
//   immediately busy=0 and RegWrite=0; after release, issue rs1=4 has no stall.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// The writeback source enum doubles as the round-robin "last grant" state.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: bit 0 is the ALU, bit 1 is the load unit.
// When both sources request, the one that did not win last time is granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  wb_src_t r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (r_last == SRC_ALU) ? 2'b10 : 2'b01;
    end
  end

  // Reset state favours the ALU on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= SRC_MEM;
    end else if (o_gnt[0]) begin
      r_last <= SRC_ALU;
    end else if (o_gnt[1]) begin
      r_last <= SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and busy-bit hazard scoreboard for a 2R/1W register file.
// ALU and load-unit writebacks share one registered write port via rr_arb2.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREG = regfile_pkg::NREG,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic          issue_wr,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  output logic          issue_stall,
  input  logic          alu_wb_valid,
  input  logic [AW-1:0] alu_wb_num,
  input  logic [DW-1:0] alu_wb_data,
  output logic          alu_wb_ready,
  input  logic          mem_wb_valid,
  input  logic [AW-1:0] mem_wb_num,
  input  logic [DW-1:0] mem_wb_data,
  output logic          mem_wb_ready,
  output logic          RegWrite,
  output logic [AW-1:0] WbRegNum,
  output logic [DW-1:0] WbData
);

  logic [NREG-1:0] r_busy;
  logic            r_reg_write;
  logic [AW-1:0]   r_wb_num;
  logic [DW-1:0]   r_wb_data;

  logic [1:0]      w_gnt;
  logic            w_wb_fire;
  logic [AW-1:0]   w_wb_num;
  logic [DW-1:0]   w_wb_data;
  logic            w_issue_acc;
  logic            w_hz_rs1;
  logic            w_hz_rs2;
  logic            w_hz_rd;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({mem_wb_valid, alu_wb_valid}),
    .o_gnt (w_gnt)
  );

  assign alu_wb_ready = w_gnt[0];
  assign mem_wb_ready = w_gnt[1];
  assign w_wb_fire    = |w_gnt;
  assign w_wb_num     = w_gnt[0] ? alu_wb_num  : mem_wb_num;
  assign w_wb_data    = w_gnt[0] ? alu_wb_data : mem_wb_data;

  // r0 never holds a pending write, so it can never raise a hazard.
  assign w_hz_rs1    = r_busy[issue_rs1] && (issue_rs1 != '0);
  assign w_hz_rs2    = r_busy[issue_rs2] && (issue_rs2 != '0);
  assign w_hz_rd     = issue_wr && r_busy[issue_rd] && (issue_rd != '0);
  assign issue_stall = issue_valid && (w_hz_rs1 || w_hz_rs2 || w_hz_rd);
  assign w_issue_acc = issue_valid && !issue_stall;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue_acc && issue_wr && (issue_rd != '0)) begin
      w_set[issue_rd] = 1'b1;
    end
    if (w_wb_fire) begin
      w_clr[w_wb_num] = 1'b1;
    end
  end

  // A same-edge set and clear of one register leaves it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_set | (r_busy & ~w_clr);
    end
  end

  // Write port register: address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_wb_num    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_reg_write <= w_wb_fire && (w_wb_num != '0);
      if (w_wb_fire) begin
        r_wb_num  <= w_wb_num;
        r_wb_data <= w_wb_data;
      end
    end
  end

  assign RegWrite = r_reg_write;
  assign WbRegNum = r_wb_num;
  assign WbData   = r_wb_data;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a reference model of busy bits,
// round-robin state and a queue of expected write-port results.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_num;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_num;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        RegWrite;
  logic [4:0]  WbRegNum;
  logic [31:0] WbData;

  typedef struct packed {
    logic        we;
    logic        g;
    logic [4:0]  n;
    logic [31:0] d;
  } wb_exp_t;

  wb_exp_t     q[$];
  logic [31:0] m_busy;
  logic        m_last;
  logic [4:0]  m_num;
  logic [31:0] m_data;
  int          checks;
  int          errors;

  regfile_wb_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_num   (alu_wb_num),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_num   (mem_wb_num),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .RegWrite     (RegWrite),
    .WbRegNum     (WbRegNum),
    .WbData       (WbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_last = 1'b1;
    m_num  = '0;
    m_data = '0;
    q.delete();
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_wr     = 1'b0;
    issue_rd     = '0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    alu_wb_valid = 1'b0;
    alu_wb_num   = '0;
    alu_wb_data  = '0;
    mem_wb_valid = 1'b0;
    mem_wb_num   = '0;
    mem_wb_data  = '0;
  endtask

  task automatic set_issue(input logic v, input logic wr, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v;
    issue_wr    = wr;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  // One clock: check combinational outputs against the model, push the
  // expected write-port result, advance the model, then pop and compare.
  task automatic step(input string tag);
    logic        es;
    logic        ea;
    logic        em;
    logic        g;
    logic [4:0]  wn;
    logic [31:0] wd;
    wb_exp_t     e;
    #1;
    es = issue_valid && ((m_busy[issue_rs1] && issue_rs1 != 5'd0) ||
                         (m_busy[issue_rs2] && issue_rs2 != 5'd0) ||
                         (issue_wr && m_busy[issue_rd] && issue_rd != 5'd0));
    ea = alu_wb_valid && (!mem_wb_valid || m_last);
    em = mem_wb_valid && !ea;
    chk({tag, ".stall"},   {31'd0, issue_stall},  {31'd0, es});
    chk({tag, ".alu_rdy"}, {31'd0, alu_wb_ready}, {31'd0, ea});
    chk({tag, ".mem_rdy"}, {31'd0, mem_wb_ready}, {31'd0, em});
    g  = ea || em;
    wn = ea ? alu_wb_num : mem_wb_num;
    wd = ea ? alu_wb_data : mem_wb_data;
    q.push_back('{we: g && (wn != 5'd0), g: g, n: wn, d: wd});
    if (g) begin
      m_busy[wn] = 1'b0;
      m_last     = em;
    end
    if (issue_valid && !es && issue_wr && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.g) begin
      m_num  = e.n;
      m_data = e.d;
    end
    chk({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, e.we});
    chk({tag, ".WbRegNum"}, {27'd0, WbRegNum}, {27'd0, m_num});
    chk({tag, ".WbData"},   WbData,            m_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst.RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst.WbRegNum", {27'd0, WbRegNum}, 32'd0);
    chk("rst.WbData",   WbData,            32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both sources valid: ALU wins the first tie, then strict alternation.
    alu_wb_valid = 1'b1; alu_wb_num = 5'd10; alu_wb_data = 32'h1111_0000;
    mem_wb_valid = 1'b1; mem_wb_num = 5'd11; mem_wb_data = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      step("rr");
      alu_wb_data = alu_wb_data + 32'd1;
      mem_wb_data = mem_wb_data + 32'd1;
    end
    idle();
    step("rr_idle");

    // Single ALU request.
    alu_wb_valid = 1'b1; alu_wb_num = 5'd5; alu_wb_data = 32'h0000_00A5;
    step("alu5");
    idle();
    step("alu5_hold");

    // RAW on r7.
    set_issue(1'b1, 1'b1, 5'd7, 5'd1, 5'd2);
    step("raw_issue");
    set_issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
    step("raw_stall0");
    step("raw_stall1");
    alu_wb_valid = 1'b1; alu_wb_num = 5'd7; alu_wb_data = 32'h0000_0777;
    step("raw_wb");
    alu_wb_valid = 1'b0;
    chk("raw_release_same_cycle", {31'd0, issue_stall}, 32'd0);
    step("raw_free");

    // WAW on r3, retired through the load unit.
    set_issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    step("waw_issue");
    step("waw_stall0");
    step("waw_stall1");
    mem_wb_valid = 1'b1; mem_wb_num = 5'd3; mem_wb_data = 32'h0003_3333;
    step("waw_wb");
    mem_wb_valid = 1'b0;
    step("waw_reissue");
    idle();
    alu_wb_valid = 1'b1; alu_wb_num = 5'd3; alu_wb_data = 32'h0000_0033;
    step("waw_clear");
    idle();

    // r0: granted but never written, never busy.
    mem_wb_valid = 1'b1; mem_wb_num = 5'd0; mem_wb_data = 32'h0000_FFFF;
    step("r0_wb");
    idle();
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    step("r0_issue");
    set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    step("r0_reissue");

    // Reset with busy[4] set and a granted write in flight.
    set_issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    alu_wb_valid = 1'b1; alu_wb_num = 5'd9; alu_wb_data = 32'h0000_0999;
    step("pre_rst");
    set_issue(1'b1, 1'b0, 5'd0, 5'd4, 5'd0);
    chk("pre_rst.stall", {31'd0, issue_stall}, 32'd1);
    alu_wb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("arst.WbRegNum", {27'd0, WbRegNum}, 32'd0);
    chk("arst.stall",    {31'd0, issue_stall}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    step("post_rst");
    idle();
    mem_wb_valid = 1'b1; mem_wb_num = 5'd12; mem_wb_data = 32'h0000_CCCC;
    alu_wb_valid = 1'b1; alu_wb_num = 5'd13; alu_wb_data = 32'h0000_DDDD;
    step("post_rst_tie");
    idle();
    step("end_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
